// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit.
// The optional alignment check is enabled by defining IFU_ALIGN_CHECK_EN.
package ifu_pkg;

  typedef enum logic [2:0] {
    BOOT = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    IDLE = 3'd4
  } ifu_state_t;

  localparam logic [31:0] INST_NOP         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  // A fetch address is misaligned when it is not on a 4-byte boundary.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ifu_pc_reg.sv
// ifu_pc_reg: architectural PC register with load enable.
// Resets asynchronously to RESET_PC.
module ifu_pc_reg
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_en,
  input  logic [31:0] pc_d,
  output logic [31:0] pc_q
);

  // PC only changes when the fetch FSM commits a new value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (load_en) begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch unit for the multi-cycle core.
// Optional feature: define IFU_ALIGN_CHECK_EN to turn misaligned fetches into
// a faulting NOP without issuing a memory request.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_next,
  input  logic        pc_update,
  output logic [31:0] pc_cur,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault
);

  ifu_state_t  state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_fault_q, inst_fault_d;
  logic        pc_load;

  ifu_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_en (pc_load),
    .pc_d    (pc_next),
    .pc_q    (pc_cur)
  );

  // State and captured-instruction registers; reset drops both valids at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_fault_q <= inst_fault_d;
    end
  end

  // Next-state, capture and handshake logic; everything holds unless a state acts.
  always_comb begin
    state_d        = state_q;
    inst_d         = inst_q;
    inst_pc_d      = inst_pc_q;
    inst_fault_d   = inst_fault_q;
    pc_load        = 1'b0;
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;

    case (state_q)
      BOOT: begin
        state_d = REQ;
      end

      REQ: begin
`ifdef IFU_ALIGN_CHECK_EN
        if (is_misaligned(pc_cur)) begin
          inst_d       = INST_NOP;
          inst_pc_d    = pc_cur;
          inst_fault_d = 1'b1;
          state_d      = HOLD;
        end else begin
          imem_req_valid = 1'b1;
          if (imem_req_ready) begin
            state_d = WAIT;
          end
        end
`else
        imem_req_valid = 1'b1;
        if (imem_req_ready) begin
          state_d = WAIT;
        end
`endif
      end

      WAIT: begin
        if (imem_rsp_valid) begin
          inst_d       = imem_rsp_data;
          inst_pc_d    = pc_cur;
          inst_fault_d = imem_rsp_err;
          state_d      = HOLD;
        end
      end

      HOLD: begin
        inst_valid = 1'b1;
        if (inst_ready) begin
          if (pc_update) begin
            pc_load = 1'b1;
            state_d = REQ;
          end else begin
            state_d = IDLE;
          end
        end
      end

      IDLE: begin
        if (pc_update) begin
          pc_load = 1'b1;
          state_d = REQ;
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign imem_req_addr = pc_cur;
  assign inst          = inst_q;
  assign inst_pc       = inst_pc_q;
  assign inst_fault    = inst_fault_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed self-checking bench for ifu_fetch.
// The alignment section follows IFU_ALIGN_CHECK_EN in the same way as the RTL.
module tb_ifu_fetch;
  import ifu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_next;
  logic        pc_update;
  logic [31:0] pc_cur;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;

  int checks;
  int errors;
  int accept_cnt;

  ifu_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_next        (pc_next),
    .pc_update      (pc_update),
    .pc_cur         (pc_cur),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault)
  );

  // Free-running core clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every accepted memory request, independent of the DUT's state.
  always @(posedge clk) begin
    if (rst_n && imem_req_valid && imem_req_ready) accept_cnt++;
  end

  // Advance to the next falling edge, where outputs are sampled and inputs driven.
  task automatic applyStimulus();
    @(negedge clk);
  endtask

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Directed sequence covering reset, fetch, backpressure, commit, fault and reset-in-WAIT.
  initial begin
    checks = 0; errors = 0; accept_cnt = 0;
    rst_n = 1'b0; pc_next = '0; pc_update = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; imem_rsp_err = 1'b0;
    inst_ready = 1'b0;

    applyStimulus();
    applyStimulus();
    checkOutput("rst_pc_cur", pc_cur, 32'h8000_0000);
    checkOutput("rst_inst", inst, 32'h0);
    checkOutput("rst_inst_pc", inst_pc, 32'h0);
    checkOutput("rst_inst_fault", inst_fault, 32'h0);
    checkOutput("rst_inst_valid", inst_valid, 32'h0);
    checkOutput("rst_req_valid", imem_req_valid, 32'h0);

    // Basic fetch
    rst_n = 1'b1;
    applyStimulus();
    checkOutput("basic_req_valid", imem_req_valid, 32'h1);
    checkOutput("basic_req_addr", imem_req_addr, 32'h8000_0000);
    imem_req_ready = 1'b1;
    applyStimulus();
    imem_req_ready = 1'b0;
    checkOutput("basic_wait_req_valid", imem_req_valid, 32'h0);
    checkOutput("basic_wait_inst_valid", inst_valid, 32'h0);
    applyStimulus();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0093;
    applyStimulus();
    imem_rsp_valid = 1'b0;
    checkOutput("basic_inst_valid", inst_valid, 32'h1);
    checkOutput("basic_inst", inst, 32'h0010_0093);
    checkOutput("basic_inst_pc", inst_pc, 32'h8000_0000);
    checkOutput("basic_inst_fault", inst_fault, 32'h0);
    inst_ready = 1'b1;
    applyStimulus();
    inst_ready = 1'b0;
    checkOutput("idle_inst_valid", inst_valid, 32'h0);
    checkOutput("idle_req_valid", imem_req_valid, 32'h0);

    // Commit from IDLE, then request backpressure for 5 cycles
    pc_next = 32'h8000_0040; pc_update = 1'b1;
    applyStimulus();
    pc_update = 1'b0;
    checkOutput("commit_pc_cur", pc_cur, 32'h8000_0040);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_req_valid", imem_req_valid, 32'h1);
      checkOutput("bp_req_addr", imem_req_addr, 32'h8000_0040);
      if (i < 4) applyStimulus();
    end
    imem_req_ready = 1'b1;
    applyStimulus();
    imem_req_ready = 1'b0;
    checkOutput("bp_wait_req_valid", imem_req_valid, 32'h0);

    // Faulting response, then decode backpressure for 4 cycles
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0020_0113; imem_rsp_err = 1'b1;
    applyStimulus();
    imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("hold_inst_valid", inst_valid, 32'h1);
      checkOutput("hold_inst", inst, 32'h0020_0113);
      checkOutput("hold_inst_pc", inst_pc, 32'h8000_0040);
      checkOutput("fault_inst_fault", inst_fault, 32'h1);
      pc_update = (i == 1); pc_next = 32'hDEAD_0000;
      applyStimulus();
    end
    pc_update = 1'b0;
    checkOutput("hold_pc_unchanged", pc_cur, 32'h8000_0040);
    checkOutput("hold_still_valid", inst_valid, 32'h1);
    checkOutput("bp_accept_count", accept_cnt, 32'd2);

    // Simultaneous handshake and commit skips IDLE
    inst_ready = 1'b1; pc_update = 1'b1; pc_next = 32'h8000_0080;
    applyStimulus();
    inst_ready = 1'b0; pc_update = 1'b0;
    checkOutput("simul_req_valid", imem_req_valid, 32'h1);
    checkOutput("simul_req_addr", imem_req_addr, 32'h8000_0080);
    checkOutput("simul_pc_cur", pc_cur, 32'h8000_0080);
    checkOutput("simul_inst_valid", inst_valid, 32'h0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hFFFF_FFFF;
    applyStimulus();
    imem_rsp_valid = 1'b0;
    checkOutput("req_rsp_ignored_valid", imem_req_valid, 32'h1);
    checkOutput("req_rsp_ignored_inst", inst, 32'h0020_0113);
    imem_req_ready = 1'b1;
    applyStimulus();
    imem_req_ready = 1'b0;
    pc_update = 1'b1; pc_next = 32'h1234_5678;
    applyStimulus();
    pc_update = 1'b0;
    checkOutput("wait_pc_ignored", pc_cur, 32'h8000_0080);
    checkOutput("wait_req_valid", imem_req_valid, 32'h0);
    checkOutput("wait_inst_valid", inst_valid, 32'h0);

    // Reset while in WAIT, stale response after release
    rst_n = 1'b0;
    #1;
    checkOutput("rstw_req_valid", imem_req_valid, 32'h0);
    checkOutput("rstw_inst_valid", inst_valid, 32'h0);
    checkOutput("rstw_pc_cur", pc_cur, 32'h8000_0000);
    checkOutput("rstw_inst", inst, 32'h0);
    checkOutput("rstw_inst_fault", inst_fault, 32'h0);
    applyStimulus();
    rst_n = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    applyStimulus();
    imem_rsp_valid = 1'b0;
    checkOutput("stale_req_valid", imem_req_valid, 32'h1);
    checkOutput("stale_req_addr", imem_req_addr, 32'h8000_0000);
    checkOutput("stale_inst", inst, 32'h0);
    checkOutput("stale_inst_valid", inst_valid, 32'h0);

    // Fresh fetch back to IDLE
    imem_req_ready = 1'b1;
    applyStimulus();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0030_0193;
    applyStimulus();
    imem_rsp_valid = 1'b0;
    checkOutput("fresh_inst", inst, 32'h0030_0193);
    checkOutput("fresh_inst_pc", inst_pc, 32'h8000_0000);
    inst_ready = 1'b1;
    applyStimulus();
    inst_ready = 1'b0;

    // Misaligned next PC
    pc_update = 1'b1; pc_next = 32'h8000_0042;
    applyStimulus();
    pc_update = 1'b0;
    checkOutput("mis_pc_cur", pc_cur, 32'h8000_0042);
`ifdef IFU_ALIGN_CHECK_EN
    checkOutput("mis_no_req", imem_req_valid, 32'h0);
    applyStimulus();
    checkOutput("mis_inst_valid", inst_valid, 32'h1);
    checkOutput("mis_inst_nop", inst, INST_NOP);
    checkOutput("mis_inst_fault", inst_fault, 32'h1);
    checkOutput("mis_inst_pc", inst_pc, 32'h8000_0042);
    checkOutput("mis_accept_count", accept_cnt, 32'd4);
`else
    checkOutput("mis_req_valid", imem_req_valid, 32'h1);
    checkOutput("mis_req_addr", imem_req_addr, 32'h8000_0042);
    imem_req_ready = 1'b1;
    applyStimulus();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0040_0213;
    applyStimulus();
    imem_rsp_valid = 1'b0;
    checkOutput("mis_inst_valid", inst_valid, 32'h1);
    checkOutput("mis_inst", inst, 32'h0040_0213);
    checkOutput("mis_inst_fault", inst_fault, 32'h0);
    checkOutput("mis_inst_pc", inst_pc, 32'h8000_0042);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit for the naive multi-cycle core: it holds the architectural PC and issues one instruction-memory request per instruction. It delivers the fetched word to decode over a valid/ready handshake, then waits for the commit pulse that loads the next-PC adder's result. It consumes the next-PC selector's output and turns it into memory traffic and a decode-side instruction stream.

## Interface
- RESET_PC, 32'h8000_0000, PC value loaded on reset
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- pc_next  in  32  next PC from the next-PC adder
- pc_update  in  1  commit pulse; load pc_next into PC
- pc_cur  out  32  architectural PC, feeds the next-PC adder
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  fetch address
- imem_rsp_valid  in  1  response valid, single cycle
- imem_rsp_data  in  32  instruction word
- imem_rsp_err  in  1  access fault on this response
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode accepts instruction
- inst  out  32  instruction word
- inst_pc  out  32  PC of inst
- inst_fault  out  1  fetch fault for inst

## Operation
- FSM states: BOOT, REQ, WAIT, HOLD, IDLE. Reset state BOOT.
- BOOT: all handshake outputs low; unconditionally goes to REQ next cycle.
- REQ: imem_req_valid=1, imem_req_addr=pc_cur. Goes to WAIT when imem_req_ready=1.
- WAIT: captures imem_rsp_data into inst, imem_rsp_err into inst_fault, pc_cur into inst_pc when imem_rsp_valid=1, then goes to HOLD.
- HOLD: inst_valid=1. On inst_ready=1, goes to IDLE. If pc_update=1 in the same cycle, it loads the PC and goes straight to REQ.
- IDLE: on pc_update=1, PC<=pc_next and goes to REQ.
- pc_update is ignored in BOOT, REQ and WAIT. The PC changes only in IDLE, or in HOLD together with an accepting handshake.
- imem_rsp_valid is ignored outside WAIT, since no request is outstanding.
- One outstanding request at most; no prefetch.

## Timing
- Reset values: pc_cur=RESET_PC, inst=0, inst_pc=0, inst_fault=0. inst_valid and imem_req_valid are 0.
- imem_req_valid and imem_req_addr are held stable from entry to REQ until accepted.
- inst, inst_pc and inst_fault are registered and stay stable for the whole time inst_valid=1.
- Minimum loop: pc_update at cycle t, REQ at t+1 (accept same cycle), WAIT at t+2 (response same cycle), inst_valid at t+3.
- Response latency is unbounded; WAIT has no timeout.
- Reset asserted mid-operation goes to BOOT immediately and drops both valids. A late response arriving after reset is ignored.

## Configuration
- IFU_ALIGN_CHECK_EN is defined: when entering REQ with pc_cur[1:0]!=0, no memory request is issued. The FSM goes REQ->HOLD in one cycle with inst=32'h0000_0013 (NOP), inst_fault=1, inst_pc=pc_cur.
- IFU_ALIGN_CHECK_EN is undefined: the request is issued with the raw address. inst_fault reflects imem_rsp_err only.

## Structure
- Package ifu_pkg holds:
  - the state enum ifu_state_t;
  - localparam INST_NOP=32'h0000_0013;
  - localparam RESET_PC_DEFAULT.
- One sub-module, ifu_pc_reg: a 32-bit PC register with async active-low reset to RESET_PC and a load enable. The FSM stays in ifu_fetch.

## Test plan
- Basic fetch:
  - Stimulus: release reset; imem_req_ready=1; response 2 cycles after accept with data 32'h0010_0093.
  - Required: imem_req_addr=32'h8000_0000; inst_valid with inst=32'h0010_0093 and inst_pc=32'h8000_0000.
- Backpressure:
  - Stimulus: imem_req_ready low for 5 cycles, then inst_ready low for 4 cycles.
  - Required: address and instruction outputs stay stable throughout; exactly one request is accepted.
- Commit:
  - Stimulus: in IDLE, pc_next=32'h8000_0040 with a pc_update pulse.
  - Required: next request address is 32'h8000_0040 and pc_cur updates the following cycle.
- Simultaneous handshake:
  - Stimulus: inst_ready and pc_update high together in HOLD.
  - Required: IDLE is skipped and REQ is asserted the next cycle.
- Fault:
  - Stimulus: imem_rsp_err=1.
  - Required: inst_fault=1.
  - With IFU_ALIGN_CHECK_EN defined, pc_next=32'h8000_0042 gives no imem_req_valid and inst=INST_NOP with inst_fault=1.
- Reset in WAIT:
  - Stimulus: assert rst_n low while in WAIT; deliver a stale response after release.
  - Required: valids drop at once; the stale response is ignored; a fresh request goes to RESET_PC.
